rtc_bus_responder: RTL and testbench



---
 rtl/rtc_bus_pkg.sv | 49 ++++
 rtl/rtc_bus_responder_bcd_pair_counter.sv | 50 +++++
 rtl/rtc_bus_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_rtc_bus_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// -----------------------------------------------------------------------------
// rtc_bus_pkg
// Shared constants and types for the RTC bus responder:
//   - register map addresses on the multiplexed address/data RTC bus
//   - reset values of the time-of-day and bus registers
//   - BCD wrap limits for seconds, minutes and hours
//   - control register bit positions
//   - a BCD range-check helper used by the digit-pair counters
// -----------------------------------------------------------------------------
package rtc_bus_pkg;

  // Register map
  localparam logic [7:0] ADDR_CTRL = 8'h00;
  localparam logic [7:0] ADDR_SEC  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HOUR = 8'h23;

  // Reset values
  localparam logic [7:0] TIME_RST    = 8'h00;
  localparam logic [7:0] ADDR_RST    = 8'h00;
  localparam logic [7:0] BUS_OUT_RST = 8'h00;

  // BCD wrap limits (value at which the next increment wraps to 0x00)
  localparam logic [7:0] SEC_LIMIT  = 8'h59;
  localparam logic [7:0] MIN_LIMIT  = 8'h59;
  localparam logic [7:0] HOUR_LIMIT = 8'h23;

  // Control/status register layout
  localparam int CTRL_HALT_BIT = 0;
  localparam int CTRL_FLAG_BIT = 7;

  // Live time-of-day, one BCD byte per field
  typedef struct packed {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
  } rtc_time_t;

  // True when value is a legal BCD pair that does not exceed limit.
  // Values written by the controller may be illegal; those are forced
  // to 0x00 (with carry) on the next increment.
  function automatic logic bcd_in_range(input logic [7:0] value,
                                        input logic [7:0] limit);
    logic ok;
    ok = (value <= limit) && (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9);
    return ok;
  endfunction

endpackage

// File: rtl/rtc_bus_responder_bcd_pair_counter.sv
// -----------------------------------------------------------------------------
// bcd_pair_counter
// Combinational next-state logic for one two-digit BCD time field.
// Ports:
//   value      in  8  current BCD value of the field
//   limit      in  8  last legal value before wrapping (0x59 or 0x23)
//   inc        in  1  advance the field by one
//   load       in  1  replace the field with load_val (wins over inc)
//   load_val   in  8  value written by the bus
//   next_value out 8  value the field takes on the next clock edge
//   carry      out 1  field wrapped to 0x00 on this increment
// -----------------------------------------------------------------------------
module bcd_pair_counter
  import rtc_bus_pkg::*;
(
  input  logic [7:0] value,
  input  logic [7:0] limit,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] next_value,
  output logic       carry
);

  // Next value and carry: a bus load discards any increment arriving this cycle
  always_comb begin
    next_value = value;
    carry      = 1'b0;
    if (load) begin
      next_value = load_val;
      carry      = 1'b0;
    end else if (inc) begin
      if (!bcd_in_range(value, limit) || (value == limit)) begin
        // Wrap at the limit; illegal contents recover the same way
        next_value = 8'h00;
        carry      = 1'b1;
      end else if (value[3:0] == 4'd9) begin
        next_value = {value[7:4] + 4'd1, 4'd0};
        carry      = 1'b0;
      end else begin
        next_value = {value[7:4], value[3:0] + 4'd1};
        carry      = 1'b0;
      end
    end else begin
      next_value = value;
      carry      = 1'b0;
    end
  end

endmodule

// File: rtl/rtc_bus_responder.sv
// -----------------------------------------------------------------------------
// rtc_bus_responder
// Far-end responder for the multiplexed address/data RTC bus. Holds a 24-hour
// BCD time of day advanced by an internal prescaler, plus a control/status
// register (bit0 halt, bit7 tick flag cleared by reading it).
// Parameters:
//   TICK_DIV  clk cycles per one-second tick (>= 2)
// Ports:
//   clk       in  1  system clock
//   reset     in  1  synchronous, active-high reset
//   cs_n      in  1  chip select, active low
//   rd_n      in  1  read strobe, active low (action on falling edge)
//   wr_n      in  1  write strobe, active low (action on rising edge)
//   a_d       in  1  0 = address phase, 1 = data phase
//   bus_in    in  8  bus value driven by the controller
//   bus_out   out 8  read data (holds last value after bus_oe drops)
//   bus_oe    out 1  responder drives the bus
//   sec_bcd   out 8  live seconds, BCD
//   min_bcd   out 8  live minutes, BCD
//   hour_bcd  out 8  live hours, BCD
//   tick_1hz  out 1  one-cycle pulse per second tick
// -----------------------------------------------------------------------------
module rtc_bus_responder
  import rtc_bus_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a_d,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       tick_1hz
);

  localparam int                  PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0]  PRESC_ZERO = {PRESC_W{1'b0}};

  // Registers
  logic               wr_prev_r;
  logic               rd_prev_r;
  logic [7:0]         addr_r;
  logic               halt_r;
  logic               tick_flag_r;
  logic [PRESC_W-1:0] presc_r;
  rtc_time_t          time_r;

  // Decoded bus events and next-state signals
  logic               wr_edge_s;
  logic               addr_wr_s;
  logic               data_wr_s;
  logic               ctrl_wr_s;
  logic               sec_wr_s;
  logic               min_wr_s;
  logic               hour_wr_s;
  logic               rd_edge_s;
  logic               ctrl_rd_s;
  logic [7:0]         read_data_s;
  logic [PRESC_W-1:0] presc_next_s;
  logic               tick_s;
  logic [7:0]         sec_next_s;
  logic [7:0]         min_next_s;
  logic [7:0]         hour_next_s;
  logic               sec_carry_s;
  logic               min_carry_s;
  logic               day_carry_unused;

  // Write strobe rising edge with chip selected; a_d selects address or data
  assign wr_edge_s = !wr_prev_r && wr_n && !cs_n;
  assign addr_wr_s = wr_edge_s && !a_d;
  assign data_wr_s = wr_edge_s && a_d;
  assign ctrl_wr_s = data_wr_s && (addr_r == ADDR_CTRL);
  assign sec_wr_s  = data_wr_s && (addr_r == ADDR_SEC);
  assign min_wr_s  = data_wr_s && (addr_r == ADDR_MIN);
  assign hour_wr_s = data_wr_s && (addr_r == ADDR_HOUR);

  // Read strobe falling edge in the data phase. wr_n must be high in both
  // the current and previous sample, so any overlap with a write strobe
  // leaves only the write to take effect.
  assign rd_edge_s = rd_prev_r && !rd_n && !cs_n && a_d && wr_n && wr_prev_r;
  assign ctrl_rd_s = rd_edge_s && (addr_r == ADDR_CTRL);

  // Read data mux: unmapped addresses read as zero
  always_comb begin
    read_data_s = 8'h00;
    case (addr_r)
      ADDR_CTRL: begin
        read_data_s                = 8'h00;
        read_data_s[CTRL_FLAG_BIT] = tick_flag_r;
        read_data_s[CTRL_HALT_BIT] = halt_r;
      end
      ADDR_SEC:  read_data_s = time_r.sec;
      ADDR_MIN:  read_data_s = time_r.min;
      ADDR_HOUR: read_data_s = time_r.hour;
      default:   read_data_s = 8'h00;
    endcase
  end

  // Prescaler: held at zero while halted; a seconds write restarts the
  // second and cancels a tick that would have landed on the same edge
  always_comb begin
    presc_next_s = presc_r;
    tick_s       = 1'b0;
    if (halt_r || sec_wr_s) begin
      presc_next_s = PRESC_ZERO;
      tick_s       = 1'b0;
    end else if (presc_r == PRESC_LAST) begin
      presc_next_s = PRESC_ZERO;
      tick_s       = 1'b1;
    end else begin
      presc_next_s = presc_r + PRESC_W'(1'b1);
      tick_s       = 1'b0;
    end
  end

  // Seconds field: advanced by the tick, overwritten by a bus write
  bcd_pair_counter u_sec (
    .value      (time_r.sec),
    .limit      (SEC_LIMIT),
    .inc        (tick_s),
    .load       (sec_wr_s),
    .load_val   (bus_in),
    .next_value (sec_next_s),
    .carry      (sec_carry_s)
  );

  // Minutes field: a bus write discards the carry from seconds
  bcd_pair_counter u_min (
    .value      (time_r.min),
    .limit      (MIN_LIMIT),
    .inc        (sec_carry_s),
    .load       (min_wr_s),
    .load_val   (bus_in),
    .next_value (min_next_s),
    .carry      (min_carry_s)
  );

  // Hours field: wraps at 23, the day carry has no consumer
  bcd_pair_counter u_hour (
    .value      (time_r.hour),
    .limit      (HOUR_LIMIT),
    .inc        (min_carry_s),
    .load       (hour_wr_s),
    .load_val   (bus_in),
    .next_value (hour_next_s),
    .carry      (day_carry_unused)
  );

  // Strobe history for edge detection; wr_prev resets high and rd_prev low
  // so a strobe already low at reset release does nothing until it goes high
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_prev_r <= 1'b1;
      rd_prev_r <= 1'b0;
    end else begin
      wr_prev_r <= wr_n;
      rd_prev_r <= rd_n;
    end
  end

  // Address latch, halt bit and tick flag (a tick sets the flag even when
  // the control register is read on the same edge)
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r      <= ADDR_RST;
      halt_r      <= 1'b0;
      tick_flag_r <= 1'b0;
    end else begin
      if (addr_wr_s) begin
        addr_r <= bus_in;
      end
      if (ctrl_wr_s) begin
        halt_r <= bus_in[CTRL_HALT_BIT];
      end
      if (tick_s) begin
        tick_flag_r <= 1'b1;
      end else if (ctrl_rd_s) begin
        tick_flag_r <= 1'b0;
      end
    end
  end

  // Time of day, prescaler and tick pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      time_r   <= '{hour: TIME_RST, min: TIME_RST, sec: TIME_RST};
      presc_r  <= PRESC_ZERO;
      tick_1hz <= 1'b0;
    end else begin
      time_r   <= '{hour: hour_next_s, min: min_next_s, sec: sec_next_s};
      presc_r  <= presc_next_s;
      tick_1hz <= tick_s;
    end
  end

  // Read response: data captured at the read edge, driven until the
  // strobe or chip select is seen high; bus_out keeps its last value
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_out <= BUS_OUT_RST;
      bus_oe  <= 1'b0;
    end else if (rd_edge_s) begin
      bus_out <= read_data_s;
      bus_oe  <= 1'b1;
    end else if (bus_oe && (rd_n || cs_n)) begin
      bus_oe  <= 1'b0;
    end
  end

  assign sec_bcd  = time_r.sec;
  assign min_bcd  = time_r.min;
  assign hour_bcd = time_r.hour;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_responder
// Directed self-checking bench for rtc_bus_responder with TICK_DIV = 10.
// Bus cycles are driven one clock step at a time; outputs are sampled 1 ns
// after the rising edge. Expected values are hand-computed from the cycle
// count since the last seconds write (which restarts the prescaler).
// -----------------------------------------------------------------------------
module tb_rtc_bus_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a_d;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       tick_1hz;

  int total    = 0;
  int bad      = 0;
  int tick_cnt = 0;
  int t0       = 0;

  always #5 clk = ~clk;

  rtc_bus_responder #(.TICK_DIV(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .a_d      (a_d),
    .bus_in   (bus_in),
    .bus_out  (bus_out),
    .bus_oe   (bus_oe),
    .sec_bcd  (sec_bcd),
    .min_bcd  (min_bcd),
    .hour_bcd (hour_bcd),
    .tick_1hz (tick_1hz)
  );

  // Advance one clock and count tick pulses seen at the sample point
  task automatic step();
    @(posedge clk);
    #1;
    if (tick_1hz === 1'b1) tick_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Address phase then data phase; the data write lands on the 4th edge
  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    cs_n = 1'b0; a_d = 1'b0; bus_in = addr; wr_n = 1'b0;
    step();
    wr_n = 1'b1;
    step();
    a_d = 1'b1; bus_in = data; wr_n = 1'b0;
    step();
    wr_n = 1'b1;
    step();
    cs_n = 1'b1; a_d = 1'b0;
  endtask

  // Address phase then read; the read edge is the 3rd edge, oe drops on the 4th
  task automatic bus_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    cs_n = 1'b0; a_d = 1'b0; bus_in = addr; wr_n = 1'b0;
    step();
    wr_n = 1'b1;
    step();
    check({tag, "_oe_before"}, {7'd0, bus_oe}, 8'h00);
    a_d = 1'b1; rd_n = 1'b0;
    step();
    check({tag, "_oe"}, {7'd0, bus_oe}, 8'h01);
    check({tag, "_data"}, bus_out, exp);
    rd_n = 1'b1;
    step();
    check({tag, "_oe_drop"}, {7'd0, bus_oe}, 8'h00);
    cs_n = 1'b1; a_d = 1'b0;
  endtask

  task automatic check_time(input string tag, input logic [7:0] h,
                            input logic [7:0] m, input logic [7:0] s);
    check({tag, "_hour"}, hour_bcd, h);
    check({tag, "_min"}, min_bcd, m);
    check({tag, "_sec"}, sec_bcd, s);
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a_d = 1'b0; bus_in = 8'h00;
    steps(3);
    reset = 1'b0;

    // 1: reset state and read timing
    check_time("rst", 8'h00, 8'h00, 8'h00);
    check("rst_oe", {7'd0, bus_oe}, 8'h00);
    check("rst_bus_out", bus_out, 8'h00);
    check("rst_tick", {7'd0, tick_1hz}, 8'h00);
    bus_read("t1_rd_sec", 8'h21, 8'h00);

    // 2: full rollover 23:59:58 -> 00:00:00 over two ticks
    bus_write(8'h23, 8'h23);
    bus_write(8'h22, 8'h59);
    bus_write(8'h21, 8'h58);
    t0 = tick_cnt;
    steps(10);
    check_time("t2_first", 8'h23, 8'h59, 8'h59);
    steps(10);
    check_time("t2_roll", 8'h00, 8'h00, 8'h00);
    check("t2_ticks", 8'(tick_cnt - t0), 8'd2);

    // 3: low-nibble carry, read-back, then illegal value recovery
    bus_write(8'h21, 8'h09);
    steps(10);
    check("t3_sec_10", sec_bcd, 8'h10);
    bus_read("t3_rd_sec", 8'h21, 8'h10);
    check("t3_bus_out_hold", bus_out, 8'h10);
    bus_write(8'h21, 8'h7A);
    steps(10);
    check_time("t3_illegal", 8'h00, 8'h01, 8'h00);

    // 4: halt freezes time and suppresses ticks
    bus_write(8'h00, 8'h01);
    t0 = tick_cnt;
    steps(50);
    check("t4_halt_ticks", 8'(tick_cnt - t0), 8'd0);
    check_time("t4_halt", 8'h00, 8'h01, 8'h00);
    bus_read("t4_rd_ctrl", 8'h00, 8'h81);
    bus_write(8'h00, 8'h00);
    t0 = tick_cnt;
    steps(9);
    check("t4_no_early_tick", 8'(tick_cnt - t0), 8'd0);
    step();
    check("t4_tick_at_10", {7'd0, tick_1hz}, 8'h01);
    check("t4_sec_resume", sec_bcd, 8'h01);

    // 5: tick flag read/clear, unmapped address
    bus_read("t5_flag_set", 8'h00, 8'h80);
    bus_read("t5_flag_clr", 8'h00, 8'h00);
    bus_read("t5_unmapped", 8'h55, 8'h00);
    bus_write(8'h55, 8'hFF);
    check_time("t5_after_wr55", 8'h00, 8'h01, 8'h02);
    steps(4);
    check("t5_not_halted", sec_bcd, 8'h03);
    bus_read("t5_ctrl", 8'h00, 8'h80);

    // 6: read strobe held low across reset release
    reset = 1'b1; cs_n = 1'b0; a_d = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
    steps(3);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_oe_held_rd", {7'd0, bus_oe}, 8'h00);
    end
    rd_n = 1'b1; cs_n = 1'b1; a_d = 1'b0;
    step();

    // 6: minutes write on the same edge as a 59 -> 00 seconds tick
    bus_write(8'h22, 8'h59);
    bus_write(8'h21, 8'h59);
    steps(6);
    bus_write(8'h22, 8'h42);
    check("t6_tick_now", {7'd0, tick_1hz}, 8'h01);
    check_time("t6_min_wins", 8'h00, 8'h42, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
